// File: rtl/raster_write_ctrl.sv
// raster_write_ctrl
//    Accepts geometry commands and their data beats from the SPI front end and
//    turns them into write strobes on the vertex, triangle and instance RAMs
//    and the buffer descriptor table.
//
//    state     | meaning
//    ----------+-------------------------------------------------------------
//    S_IDLE    | waiting for a command; only state with cmd_ready=1
//    S_VERT    | writing vertex beats to base+k until count beats are taken
//    S_TRI     | writing triangle beats to base+k until count beats are taken
//    S_INST    | taking the single transform beat of an instance command
//    S_DRAIN   | discarding the beats of an out-of-range buffer command
//
// Ports
//    clk, rst_sck            clock, asynchronous active-high reset
//    step                    SPI-rise qualifier; gates every handshake
//    cmd_valid/ready, cmd_*  command channel (op, id, base, count)
//    dat_valid/ready, dat    data-beat channel
//    vram_*, tram_*, iram_*  RAM write ports (single-clk strobes)
//    vdesc_we, tdesc_we,
//    desc_addr, desc_din     descriptor table write, din = {base, count}
//    busy, done, err         status; err is sticky until CLEAR_ERR
module raster_write_ctrl #(
   parameter int ADDR_W  = 13,
   parameter int CNT_W   = 12,
   parameter int ID_W    = 8,
   parameter int VTX_W   = 108,
   parameter int TRI_W   = 36,
   parameter int TRANS_W = 384,
   parameter int DAT_W   = TRANS_W
) (
   input  logic                      clk,
   input  logic                      rst_sck,
   input  logic                      step,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [3:0]                cmd_op,
   input  logic [ID_W-1:0]           cmd_id,
   input  logic [ADDR_W-1:0]         cmd_base,
   input  logic [CNT_W-1:0]          cmd_count,
   input  logic                      dat_valid,
   output logic                      dat_ready,
   input  logic [DAT_W-1:0]          dat,
   output logic                      vram_we,
   output logic [ADDR_W-1:0]         vram_addr,
   output logic [VTX_W-1:0]          vram_din,
   output logic                      tram_we,
   output logic [ADDR_W-1:0]         tram_addr,
   output logic [TRI_W-1:0]          tram_din,
   output logic                      iram_we,
   output logic [ID_W-1:0]           iram_addr,
   output logic [TRANS_W+2*ID_W-1:0] iram_din,
   output logic                      vdesc_we,
   output logic                      tdesc_we,
   output logic [ID_W-1:0]           desc_addr,
   output logic [ADDR_W+CNT_W-1:0]   desc_din,
   output logic                      busy,
   output logic                      done,
   output logic [2:0]                err
);

   localparam int NID = 1 << ID_W;

   localparam logic [3:0] OP_VERT        = 4'd1;
   localparam logic [3:0] OP_TRI         = 4'd2;
   localparam logic [3:0] OP_INST_CREATE = 4'd3;
   localparam logic [3:0] OP_INST_UPDATE = 4'd4;
   localparam logic [3:0] OP_CLEAR_ERR   = 4'd5;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_ILLEGAL = 3'd1;
   localparam logic [2:0] ERR_RANGE   = 3'd2;
   localparam logic [2:0] ERR_NO_DESC = 3'd3;
   localparam logic [2:0] ERR_NO_INST = 3'd4;

   localparam logic [ADDR_W:0] ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_VERT, S_TRI, S_INST, S_DRAIN} state_t;

   state_t state, state_nx;

   logic                cmd_fire, dat_fire;
   logic [ADDR_W:0]     end_addr;
   logic                range_bad;
   logic [2*ID_W-1:0]   inst_ids;
   logic [ID_W-1:0]     cmd_vid, cmd_tid;
   logic                inst_bad;
   logic                last_beat;

   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [ID_W-1:0]     id_q, vid_q, tid_q;
   logic                create_q, inst_err_q;
   logic [NID-1:0]      vdef, tdef, idef;

   assign cmd_fire  = cmd_valid & cmd_ready & step;
   assign dat_fire  = dat_valid & dat_ready & step;

   // One extra bit so a buffer ending exactly at the top of the RAM is legal.
   assign end_addr  = {1'b0, cmd_base} + (ADDR_W+1)'(cmd_count);
   assign range_bad = end_addr > ADDR_SPAN;

   // Instance ops carry {vert_id, tri_id} in the low bits of base; base is
   // zero-extended when it is narrower than the two ids together.
   assign inst_ids  = (2*ID_W)'(cmd_base);
   assign cmd_vid   = inst_ids[2*ID_W-1:ID_W];
   assign cmd_tid   = inst_ids[ID_W-1:0];
   assign inst_bad  = (cmd_op == OP_INST_CREATE) ? !(vdef[cmd_vid] && tdef[cmd_tid])
                                                 : !idef[cmd_id];
   assign last_beat = cnt_q == CNT_W'(1);

   always_ff @(posedge clk or posedge rst_sck) begin
      if (rst_sck) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (cmd_fire) begin
               case (cmd_op)
                  OP_VERT, OP_TRI: begin
                     if (cmd_count != '0) begin
                        if (range_bad)            state_nx = S_DRAIN;
                        else if (cmd_op == OP_VERT) state_nx = S_VERT;
                        else                      state_nx = S_TRI;
                     end
                  end
                  OP_INST_CREATE, OP_INST_UPDATE: state_nx = S_INST;
                  default: state_nx = S_IDLE;
               endcase
            end
         end
         S_VERT, S_TRI, S_DRAIN: if (dat_fire && last_beat) state_nx = S_IDLE;
         S_INST:                 if (dat_fire) state_nx = S_IDLE;
         default:                state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = state == S_IDLE;
      dat_ready = state != S_IDLE;
      busy      = state != S_IDLE;
   end

   always_ff @(posedge clk or posedge rst_sck) begin
      if (rst_sck) begin
         vram_we    <= 1'b0;
         vram_addr  <= '0;
         vram_din   <= '0;
         tram_we    <= 1'b0;
         tram_addr  <= '0;
         tram_din   <= '0;
         iram_we    <= 1'b0;
         iram_addr  <= '0;
         iram_din   <= '0;
         vdesc_we   <= 1'b0;
         tdesc_we   <= 1'b0;
         desc_addr  <= '0;
         desc_din   <= '0;
         done       <= 1'b0;
         err        <= ERR_NONE;
         addr_q     <= '0;
         cnt_q      <= '0;
         id_q       <= '0;
         vid_q      <= '0;
         tid_q      <= '0;
         create_q   <= 1'b0;
         inst_err_q <= 1'b0;
         vdef       <= '0;
         tdef       <= '0;
         idef       <= '0;
      end else begin
         vram_we  <= 1'b0;
         tram_we  <= 1'b0;
         iram_we  <= 1'b0;
         vdesc_we <= 1'b0;
         tdesc_we <= 1'b0;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_fire) begin
                  case (cmd_op)
                     OP_VERT, OP_TRI: begin
                        addr_q <= cmd_base;
                        cnt_q  <= cmd_count;
                        if (range_bad) begin
                           if (err == ERR_NONE) err <= ERR_RANGE;
                        end else begin
                           vdesc_we  <= cmd_op == OP_VERT;
                           tdesc_we  <= cmd_op == OP_TRI;
                           desc_addr <= cmd_id;
                           desc_din  <= {cmd_base, cmd_count};
                           if (cmd_op == OP_VERT) vdef[cmd_id] <= 1'b1;
                           else                   tdef[cmd_id] <= 1'b1;
                        end
                        if (cmd_count == '0) done <= 1'b1;
                     end
                     OP_INST_CREATE, OP_INST_UPDATE: begin
                        id_q       <= cmd_id;
                        vid_q      <= cmd_vid;
                        tid_q      <= cmd_tid;
                        create_q   <= cmd_op == OP_INST_CREATE;
                        inst_err_q <= inst_bad;
                        if (inst_bad && err == ERR_NONE)
                           err <= (cmd_op == OP_INST_CREATE) ? ERR_NO_DESC : ERR_NO_INST;
                     end
                     OP_CLEAR_ERR: begin
                        err  <= ERR_NONE;
                        done <= 1'b1;
                     end
                     default: begin
                        if (err == ERR_NONE) err <= ERR_ILLEGAL;
                        done <= 1'b1;
                     end
                  endcase
               end
            end
            S_VERT, S_TRI, S_DRAIN: begin
               if (dat_fire) begin
                  if (state == S_VERT) begin
                     vram_we   <= 1'b1;
                     vram_addr <= addr_q;
                     vram_din  <= dat[VTX_W-1:0];
                  end
                  if (state == S_TRI) begin
                     tram_we   <= 1'b1;
                     tram_addr <= addr_q;
                     tram_din  <= dat[TRI_W-1:0];
                  end
                  addr_q <= addr_q + ADDR_W'(1);
                  cnt_q  <= cnt_q - CNT_W'(1);
                  if (last_beat) done <= 1'b1;
               end
            end
            S_INST: begin
               if (dat_fire) begin
                  done <= 1'b1;
                  if (!inst_err_q) begin
                     iram_we   <= 1'b1;
                     iram_addr <= id_q;
                     iram_din  <= {dat[TRANS_W-1:0], vid_q, tid_q};
                     if (create_q) idef[id_q] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_raster_write_ctrl.sv
module tb_raster_write_ctrl;

   localparam int ADDR_W  = 13;
   localparam int CNT_W   = 12;
   localparam int ID_W    = 8;
   localparam int VTX_W   = 108;
   localparam int TRI_W   = 36;
   localparam int TRANS_W = 384;
   localparam int DAT_W   = TRANS_W;
   localparam int SBW     = TRANS_W + 2*ID_W;

   localparam int K_VDESC = 0;
   localparam int K_TDESC = 1;
   localparam int K_VRAM  = 2;
   localparam int K_TRAM  = 3;
   localparam int K_IRAM  = 4;

   logic                      clk = 1'b0;
   logic                      rst_sck;
   logic                      step;
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [3:0]                cmd_op;
   logic [ID_W-1:0]           cmd_id;
   logic [ADDR_W-1:0]         cmd_base;
   logic [CNT_W-1:0]          cmd_count;
   logic                      dat_valid;
   logic                      dat_ready;
   logic [DAT_W-1:0]          dat;
   logic                      vram_we;
   logic [ADDR_W-1:0]         vram_addr;
   logic [VTX_W-1:0]          vram_din;
   logic                      tram_we;
   logic [ADDR_W-1:0]         tram_addr;
   logic [TRI_W-1:0]          tram_din;
   logic                      iram_we;
   logic [ID_W-1:0]           iram_addr;
   logic [SBW-1:0]            iram_din;
   logic                      vdesc_we;
   logic                      tdesc_we;
   logic [ID_W-1:0]           desc_addr;
   logic [ADDR_W+CNT_W-1:0]   desc_din;
   logic                      busy;
   logic                      done;
   logic [2:0]                err;

   raster_write_ctrl #(
      .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ID_W(ID_W), .VTX_W(VTX_W),
      .TRI_W(TRI_W), .TRANS_W(TRANS_W), .DAT_W(DAT_W)
   ) dut (
      .clk(clk), .rst_sck(rst_sck), .step(step),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_id(cmd_id), .cmd_base(cmd_base), .cmd_count(cmd_count),
      .dat_valid(dat_valid), .dat_ready(dat_ready), .dat(dat),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_din(vram_din),
      .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
      .iram_we(iram_we), .iram_addr(iram_addr), .iram_din(iram_din),
      .vdesc_we(vdesc_we), .tdesc_we(tdesc_we), .desc_addr(desc_addr),
      .desc_din(desc_din), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              kind;
      logic [15:0]     addr;
      logic [SBW-1:0]  data;
   } sb_t;

   typedef struct {
      logic [3:0]         op;
      logic [ID_W-1:0]    id;
      logic [ADDR_W-1:0]  base;
      logic [CNT_W-1:0]   cnt;
      int                 beats;
      bit                 ok;
      logic [2:0]         err;
   } vec_t;

   sb_t  sb[$];
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;
   int   wr_cnt = 0;
   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   task automatic got_write(input int kind, input logic [15:0] a, input logic [SBW-1:0] d);
      sb_t e;
      wr_cnt++;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL unexpected_write: got kind=%0d addr=%0d, want no write", kind, a);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.addr !== a || e.data !== d) begin
            bad++;
            $display("FAIL write: got kind=%0d addr=%0d data=%h, want kind=%0d addr=%0d data=%h",
                     kind, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      if (vdesc_we) got_write(K_VDESC, 16'(desc_addr), SBW'(desc_din));
      if (tdesc_we) got_write(K_TDESC, 16'(desc_addr), SBW'(desc_din));
      if (vram_we)  got_write(K_VRAM, 16'(vram_addr), SBW'(vram_din));
      if (tram_we)  got_write(K_TRAM, 16'(tram_addr), SBW'(tram_din));
      if (iram_we)  got_write(K_IRAM, 16'(iram_addr), iram_din);
      if (done) done_cnt++;
   end

   task automatic push(input int kind, input logic [15:0] a, input logic [SBW-1:0] d);
      sb_t e;
      e.kind = kind;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic rand_beat(output logic [DAT_W-1:0] b);
      for (int j = 0; j < DAT_W/32; j++) b[j*32 +: 32] = $urandom;
   endtask

   task automatic send_cmd(input vec_t v);
      int to;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_id    = v.id;
      cmd_base  = v.base;
      cmd_count = v.cnt;
      to = 0;
      while (!cmd_ready && to < 50) begin
         @(negedge clk);
         to++;
      end
      if (to >= 50) chk("cmd_ready_timeout", 32'(to), 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [DAT_W-1:0] b);
      int to;
      dat_valid = 1'b1;
      dat = b;
      to = 0;
      while (!dat_ready && to < 50) begin
         @(negedge clk);
         to++;
      end
      if (to >= 50) chk("dat_ready_timeout", 32'(to), 32'd0);
      @(negedge clk);
      dat_valid = 1'b0;
   endtask

   task automatic run_cmd(input vec_t v, input int stall_at);
      logic [DAT_W-1:0] b;
      logic [15:0]      b16;
      int               d0, w0, to;
      d0  = done_cnt;
      b16 = 16'(v.base);
      if (v.ok && v.op == 4'd1) push(K_VDESC, 16'(v.id), SBW'({v.base, v.cnt}));
      if (v.ok && v.op == 4'd2) push(K_TDESC, 16'(v.id), SBW'({v.base, v.cnt}));
      send_cmd(v);
      for (int k = 0; k < v.beats; k++) begin
         rand_beat(b);
         if (v.ok && v.op == 4'd1) push(K_VRAM, 16'(v.base + ADDR_W'(k)), SBW'(b[VTX_W-1:0]));
         if (v.ok && v.op == 4'd2) push(K_TRAM, 16'(v.base + ADDR_W'(k)), SBW'(b[TRI_W-1:0]));
         if (v.ok && (v.op == 4'd3 || v.op == 4'd4))
            push(K_IRAM, 16'(v.id), {b[TRANS_W-1:0], b16[15:8], b16[7:0]});
         if (k == stall_at) begin
            step = 1'b0;
            dat_valid = 1'b1;
            dat = b;
            @(negedge clk);
            w0 = wr_cnt;
            repeat (10) @(negedge clk);
            chk("stall_no_strobe", 32'(wr_cnt), 32'(w0));
            chk("stall_dat_ready", 32'(dat_ready), 32'd1);
            chk("stall_no_done", 32'(done_cnt), 32'(d0));
            step = 1'b1;
         end
         send_beat(b);
      end
      to = 0;
      while (done_cnt == d0 && to < 40) begin
         @(negedge clk);
         to++;
      end
      repeat (2) @(negedge clk);
      chk("done_once", 32'(done_cnt), 32'(d0 + 1));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("err", 32'(err), 32'(v.err));
      chk("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DAT_W-1:0] b;
      vec_t v;
      int   w0;

      tbl[0]  = '{4'd1, 8'd3,  13'd100,  12'd3, 3, 1'b1, 3'd0};
      tbl[1]  = '{4'd2, 8'd2,  13'd8190, 12'd4, 4, 1'b0, 3'd2};
      tbl[2]  = '{4'd5, 8'd0,  13'd0,    12'd0, 0, 1'b0, 3'd0};
      tbl[3]  = '{4'd4, 8'd7,  13'd0,    12'd0, 1, 1'b0, 3'd4};
      tbl[4]  = '{4'd9, 8'd0,  13'd0,    12'd0, 0, 1'b0, 3'd4};
      tbl[5]  = '{4'd5, 8'd0,  13'd0,    12'd0, 0, 1'b0, 3'd0};
      tbl[6]  = '{4'd1, 8'd1,  13'd200,  12'd2, 2, 1'b1, 3'd0};
      tbl[7]  = '{4'd2, 8'd2,  13'd50,   12'd3, 3, 1'b1, 3'd0};
      tbl[8]  = '{4'd3, 8'd5,  13'd258,  12'd0, 1, 1'b1, 3'd0};
      tbl[9]  = '{4'd4, 8'd5,  13'd0,    12'd0, 1, 1'b1, 3'd0};
      tbl[10] = '{4'd1, 8'd9,  13'd8190, 12'd2, 2, 1'b1, 3'd0};
      tbl[11] = '{4'd1, 8'd10, 13'd0,    12'd0, 0, 1'b1, 3'd0};
      tbl[12] = '{4'd0, 8'd0,  13'd0,    12'd0, 0, 1'b0, 3'd1};
      tbl[13] = '{4'd3, 8'd6,  13'd1026, 12'd0, 1, 1'b0, 3'd1};
      tbl[14] = '{4'd5, 8'd0,  13'd0,    12'd0, 0, 1'b0, 3'd0};
      tbl[15] = '{4'd1, 8'd3,  13'd400,  12'd1, 1, 1'b1, 3'd0};

      rst_sck = 1'b1;
      step = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_id = '0;
      cmd_base = '0;
      cmd_count = '0;
      dat_valid = 1'b0;
      dat = '0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_dat_ready", 32'(dat_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_we", 32'({vram_we, tram_we, iram_we, vdesc_we, tdesc_we}), 32'd0);
      rst_sck = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) run_cmd(tbl[i], -1);

      // step held low for 10+ clocks in the middle of a vertex buffer
      v = '{4'd1, 8'd12, 13'd300, 12'd3, 3, 1'b1, 3'd0};
      run_cmd(v, 1);

      // reset after the first of four beats
      v = '{4'd1, 8'd13, 13'd400, 12'd4, 4, 1'b1, 3'd0};
      push(K_VDESC, 16'(v.id), SBW'({v.base, v.cnt}));
      send_cmd(v);
      chk("mid_busy", 32'(busy), 32'd1);
      rand_beat(b);
      push(K_VRAM, 16'(v.base), SBW'(b[VTX_W-1:0]));
      send_beat(b);
      @(negedge clk);
      rst_sck = 1'b1;
      @(negedge clk);
      w0 = wr_cnt;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_dat_ready", 32'(dat_ready), 32'd0);
      repeat (3) @(negedge clk);
      rst_sck = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rst_no_strobe", 32'(wr_cnt), 32'(w0));
      chk("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);

      // bitmaps were cleared, so the earlier vert 1 / tri 2 are gone
      v = '{4'd3, 8'd5, 13'd258, 12'd0, 1, 1'b0, 3'd3};
      run_cmd(v, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
